// File: rtl/sparse_adder64_core.sv
// 64-bit sparse-carry adder: Kogge-Stone group prefix plus conditional-sum groups, with a registered copy.
// Optional carry-in port enabled by defining SPARSE_ADDER64_CIN_EN.
module sparse_adder64_core #(
    parameter int SPARSITY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] A,
    input  logic [63:0] B,
`ifdef SPARSE_ADDER64_CIN_EN
    input  logic        CIN,
`endif
    output logic [63:0] SUM,
    output logic        CO,
    output logic [63:0] SUM_R,
    output logic        CO_R
);

    localparam int NG     = 64 / SPARSITY;
    localparam int LEVELS = $clog2(NG);

    generate
        if (SPARSITY != 2 && SPARSITY != 4 && SPARSITY != 8) begin : g_bad_sparsity
            $fatal(1, "sparse_adder64_core: SPARSITY must be 2, 4 or 8");
        end
    endgenerate

    logic cin;
`ifdef SPARSE_ADDER64_CIN_EN
    assign cin = CIN;
`else
    assign cin = 1'b0;
`endif

    logic [63:0]   g_bit;
    logic [63:0]   p_bit;
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG-1:0] grp_cout;
    logic [NG-1:0] grp_cin;

    assign g_bit = A & B;
    assign p_bit = A ^ B;

    // Carry into group k is the prefix carry out of group k-1; group 0 sees cin directly.
    assign grp_cin = {grp_cout[NG-2:0], cin};
    assign CO      = grp_cout[NG-1];

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            logic [SPARSITY:0]   c0;
            logic [SPARSITY:0]   c1;
            logic [SPARSITY-1:0] sum0;
            logic [SPARSITY-1:0] sum1;

            always_comb begin
                c0    = '0;
                c1    = '0;
                c0[0] = 1'b0;
                c1[0] = 1'b1;
                for (int b = 0; b < SPARSITY; b++) begin
                    c0[b+1] = g_bit[gi*SPARSITY+b] | (p_bit[gi*SPARSITY+b] & c0[b]);
                    c1[b+1] = g_bit[gi*SPARSITY+b] | (p_bit[gi*SPARSITY+b] & c1[b]);
                end
            end

            assign sum0 = p_bit[gi*SPARSITY +: SPARSITY] ^ c0[SPARSITY-1:0];
            assign sum1 = p_bit[gi*SPARSITY +: SPARSITY] ^ c1[SPARSITY-1:0];

            // The ripple carry-out with carry-in 0 is exactly the group generate term.
            assign grp_g[gi] = c0[SPARSITY];
            assign grp_p[gi] = &p_bit[gi*SPARSITY +: SPARSITY];

            assign SUM[gi*SPARSITY +: SPARSITY] = grp_cin[gi] ? sum1 : sum0;
        end
    endgenerate

    // Kogge-Stone prefix over group (G,P) pairs, cin folded into group 0.
    always_comb begin
        logic [NG-1:0] kg;
        logic [NG-1:0] kp;
        logic [NG-1:0] nx_g;
        logic [NG-1:0] nx_p;
        kg    = grp_g;
        kp    = grp_p;
        kg[0] = grp_g[0] | (grp_p[0] & cin);
        nx_g  = kg;
        nx_p  = kp;
        for (int l = 0; l < LEVELS; l++) begin
            nx_g = kg;
            nx_p = kp;
            for (int i = 0; i < NG; i++) begin
                if (i >= (1 << l)) begin
                    nx_g[i] = kg[i] | (kp[i] & kg[i-(1<<l)]);
                    nx_p[i] = kp[i] & kp[i-(1<<l)];
                end
            end
            kg = nx_g;
            kp = nx_p;
        end
        grp_cout = kg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            SUM_R <= 64'h0;
            CO_R  <= 1'b0;
        end else begin
            SUM_R <= SUM;
            CO_R  <= CO;
        end
    end

endmodule

// File: tb/tb_sparse_adder64_core.sv
// Scoreboard bench for sparse_adder64_core: one DUT per SPARSITY (2, 4, 8), all checked against the same expectations.
// Directed vectors carry hand-computed results; random pairs use a 65-bit reference sum.
module tb_sparse_adder64_core;

    typedef struct {
        bit          is_reg;
        string       nm;
        logic [64:0] exp;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] a_drv = '1;
    logic [63:0] b_drv = '1;
    logic        cin_drv = 1'b0;

    logic [63:0] sum_w   [3];
    logic        co_w    [3];
    logic [63:0] sum_r_w [3];
    logic        co_r_w  [3];

    item_t exp_q[$];
    event  sample_ev;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_txn = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            sparse_adder64_core #(.SPARSITY(2 << gi)) u_dut (
                .clk   (clk),
                .rst   (rst),
                .A     (a_drv),
                .B     (b_drv),
`ifdef SPARSE_ADDER64_CIN_EN
                .CIN   (cin_drv),
`endif
                .SUM   (sum_w[gi]),
                .CO    (co_w[gi]),
                .SUM_R (sum_r_w[gi]),
                .CO_R  (co_r_w[gi])
            );
        end
    endgenerate

    // Monitor: pops every pending expectation when the stimulus strobes a sample point.
    initial begin
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                item_t it;
                logic [64:0] act;
                bit ok;
                it = exp_q.pop_front();
                ok = 1'b1;
                for (int d = 0; d < 3; d++) begin
                    act = it.is_reg ? {co_r_w[d], sum_r_w[d]} : {co_w[d], sum_w[d]};
                    n_cmp++;
                    if (act !== it.exp) begin
                        n_bad++;
                        ok = 1'b0;
                        $display("FAIL %s sparsity=%0d got={co,sum}=%h want=%h", it.nm, 2 << d, act, it.exp);
                    end
                end
                n_txn++;
                $display("txn %0d %s exp=%h %s", n_txn, it.nm, it.exp, ok ? "ok" : "bad");
            end
        end
    end

    task automatic apply(input string nm, input logic [63:0] a, input logic [63:0] b,
                         input logic c, input logic r, input logic [64:0] exp_c,
                         input logic chk_r, input logic [64:0] exp_r);
        item_t it;
        @(posedge clk);
        #1;
        a_drv   = a;
        b_drv   = b;
        cin_drv = c;
        rst     = r;
        it.is_reg = 1'b0;
        it.nm     = nm;
        it.exp    = exp_c;
        exp_q.push_back(it);
        #2;
        ->sample_ev;
        if (chk_r) begin
            @(posedge clk);
            #1;
            it.is_reg = 1'b1;
            it.nm     = {nm, "_r"};
            it.exp    = exp_r;
            exp_q.push_back(it);
            ->sample_ev;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;
        logic [64:0] rexp;

        // Reset held across two edges: registered copy cleared, combinational path unaffected.
        apply("rst0", '1, '1, 1'b0, 1'b1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b1, 65'h0);
        apply("rst1", '1, '1, 1'b0, 1'b1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b1, 65'h0);

        apply("ones_plus1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
              {1'b1, 64'h0}, 1'b1, {1'b1, 64'h0});
        apply("grp_bound", 64'h0000_0000_0000_000F, 64'h1, 1'b0, 1'b0,
              {1'b0, 64'h10}, 1'b1, {1'b0, 64'h10});
        apply("msb_msb", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
              {1'b1, 64'h0}, 1'b1, {1'b1, 64'h0});
        apply("zero_zero", 64'h0, 64'h0, 1'b0, 1'b0, {1'b0, 64'h0}, 1'b1, {1'b0, 64'h0});
        apply("low32_carry", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
              {1'b0, 64'h0000_0001_0000_0000}, 1'b0, 65'h0);
        apply("top_nibble", 64'h0FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
              {1'b0, 64'h1000_0000_0000_0000}, 1'b0, 65'h0);
        apply("alt_pattern", 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0,
              {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, 65'h0);
        apply("mixed", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3211, 1'b0, 1'b0,
              {1'b1, 64'h0}, 1'b0, 65'h0);

        // Mid-stream reset wins over capture, then capture resumes.
        apply("pre_rst", 64'h1234, 64'h1, 1'b0, 1'b0, {1'b0, 64'h1235}, 1'b1, {1'b0, 64'h1235});
        apply("mid_rst", 64'h1234, 64'h1, 1'b0, 1'b1, {1'b0, 64'h1235}, 1'b1, 65'h0);
        apply("resume", 64'h5, 64'h6, 1'b0, 1'b0, {1'b0, 64'hB}, 1'b1, {1'b0, 64'hB});

`ifdef SPARSE_ADDER64_CIN_EN
        apply("cin_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
              {1'b1, 64'h0}, 1'b1, {1'b1, 64'h0});
        apply("cin_small", 64'h7, 64'h8, 1'b1, 1'b0, {1'b0, 64'h10}, 1'b0, 65'h0);
`endif

        for (int i = 0; i < 4000; i++) begin
            ra = (i < 2000) ? {32'h0, $urandom()} : {$urandom(), $urandom()};
            rb = (i < 2000) ? {32'h0, $urandom()} : {$urandom(), $urandom()};
`ifdef SPARSE_ADDER64_CIN_EN
            rc = 1'($urandom_range(1, 0));
`else
            rc = 1'b0;
`endif
            rexp = {1'b0, ra} + {1'b0, rb} + {64'h0, rc};
            apply((i < 2000) ? "rand32" : "rand64", ra, rb, rc, 1'b0, rexp, 1'b0, 65'h0);
        end

        @(posedge clk);
        #5;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
